// File: rtl/sram_like_pkg.sv
// Shared types and constants for the data-side sram_like responder.
package sram_like_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/byte_sel_decode.sv
// Decodes core byte selects into sram_like size and byte offset; flags unsupported patterns.
module byte_sel_decode
    import sram_like_pkg::*;
(
    input  logic [3:0] sel,
    output logic [1:0] size,
    output logic [1:0] offset,
    output logic       illegal
);

    always_comb begin
        size    = SIZE_WORD;
        offset  = 2'd0;
        illegal = 1'b0;
        case (sel)
            // 0000 is a plain word read; a store with it is rejected by the caller
            4'b1111, 4'b0000: begin
                size = SIZE_WORD;
            end
            4'b0011: size = SIZE_HALF;
            4'b1100: begin
                size   = SIZE_HALF;
                offset = 2'd2;
            end
            4'b0001: size = SIZE_BYTE;
            4'b0010: begin
                size   = SIZE_BYTE;
                offset = 2'd1;
            end
            4'b0100: begin
                size   = SIZE_BYTE;
                offset = 2'd2;
            end
            4'b1000: begin
                size   = SIZE_BYTE;
                offset = 2'd3;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/d_sram_like_responder.sv
// Turns stall-style core data accesses into single sram_like transactions toward the AXI bridge.
// Optional DSRAM_ADDR_MAP_EN: strip kseg0/kseg1 addresses to physical (clear addr[31:29]).
module d_sram_like_responder
    import sram_like_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_rd,
    input  logic              core_wr,
    input  logic [3:0]        core_sel,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              data_stall,
    input  logic              longest_stall,
    input  logic              cancel,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [DATA_W-1:0] data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [DATA_W-1:0] data_rdata
);

    state_t            stateQ, stateD;
    logic              cancelledQ, cancelledD;
    logic              captureReq, captureData;
    logic              access;
    logic [1:0]        selSize, selOffset;
    logic              selIllegal;
    logic [ADDR_W-1:0] alignedAddr, mappedAddr;

    byte_sel_decode u_byteSelDecode (
        .sel    (core_sel),
        .size   (selSize),
        .offset (selOffset),
        .illegal(selIllegal)
    );

    assign access      = (core_rd | core_wr) & ~cancel;
    assign alignedAddr = {core_addr[ADDR_W-1:2], selOffset};

`ifdef DSRAM_ADDR_MAP_EN
    always_comb begin
        mappedAddr = alignedAddr;
        if (alignedAddr[ADDR_W-1 -: 2] == 2'b10) begin
            mappedAddr = {3'b000, alignedAddr[ADDR_W-4:0]};
        end
    end
`else
    assign mappedAddr = alignedAddr;
`endif

    always_comb begin
        stateD      = stateQ;
        cancelledD  = cancelledQ;
        captureReq  = 1'b0;
        captureData = 1'b0;
        case (stateQ)
            IDLE: begin
                if (access) begin
                    stateD     = REQ;
                    captureReq = 1'b1;
                    cancelledD = 1'b0;
                end
            end
            REQ: begin
                if (data_addr_ok) begin
                    if (data_data_ok) begin
                        if (cancel) begin
                            stateD = IDLE;
                        end else begin
                            stateD      = DONE;
                            captureData = 1'b1;
                        end
                    end else begin
                        stateD     = WAIT;
                        cancelledD = cancel;
                    end
                end else if (cancel) begin
                    stateD = IDLE;
                end
            end
            WAIT: begin
                // A handshaken request must still be drained; a flushed one just discards the data
                if (data_data_ok) begin
                    if (cancelledQ | cancel) begin
                        stateD = IDLE;
                    end else begin
                        stateD      = DONE;
                        captureData = 1'b1;
                    end
                end else if (cancel) begin
                    cancelledD = 1'b1;
                end
            end
            DONE: begin
                if (!longest_stall) begin
                    stateD = IDLE;
                end
            end
            default: stateD = IDLE;
        endcase
    end

    assign data_req   = (stateQ == REQ);
    assign data_stall = (stateQ != DONE) & access;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateQ     <= IDLE;
            cancelledQ <= 1'b0;
            data_wr    <= 1'b0;
            data_size  <= SIZE_BYTE;
            data_addr  <= '0;
            data_wdata <= '0;
            core_rdata <= '0;
        end else begin
            stateQ     <= stateD;
            cancelledQ <= cancelledD;
            if (captureReq) begin
                data_wr    <= core_wr;
                data_size  <= selSize;
                data_addr  <= mappedAddr;
                data_wdata <= core_wdata;
            end
            if (captureData && !data_wr) begin
                core_rdata <= data_rdata;
            end
        end
    end

    assert property (@(posedge clk) disable iff (!rst)
        (stateQ == IDLE && access) |->
            !(selIllegal || (core_rd && core_wr) || (core_wr && core_sel == 4'b0000)));

endmodule

// File: tb/tb_d_sram_like_responder.sv
// Directed bench for d_sram_like_responder with a bus-request and load-data scoreboard.
module tb_d_sram_like_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_rd, core_wr, longest_stall, cancel;
    logic [3:0]  core_sel;
    logic [31:0] core_addr, core_wdata, core_rdata;
    logic        data_stall, data_req, data_wr, data_addr_ok, data_data_ok;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } busReq_t;

    busReq_t     reqQ[$];
    logic [31:0] rdQ[$];
    int          passCnt = 0;
    int          failCnt = 0;
    int          hsCnt = 0;
    logic [31:0] lastRdata = 32'h0;

    always #5 clk = ~clk;

    d_sram_like_responder dut (
        .clk          (clk),
        .rst          (rst),
        .core_rd      (core_rd),
        .core_wr      (core_wr),
        .core_sel     (core_sel),
        .core_addr    (core_addr),
        .core_wdata   (core_wdata),
        .core_rdata   (core_rdata),
        .data_stall   (data_stall),
        .longest_stall(longest_stall),
        .cancel       (cancel),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert (obs === exp) begin
            passCnt++;
        end else begin
            failCnt++;
            $error("FAIL %s: observed %h, required %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] expMap(input logic [31:0] a);
`ifdef DSRAM_ADDR_MAP_EN
        return (a[31:30] == 2'b10) ? {3'b000, a[28:0]} : a;
`else
        return a;
`endif
    endfunction

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Bus monitor: every accepted request must match the oldest expected one
    always @(negedge clk) begin
        busReq_t e;
        if (rst && data_req && data_addr_ok) begin
            hsCnt++;
            check("hs_expected", 32'(reqQ.size() != 0), 32'd1);
            if (reqQ.size() != 0) begin
                e = reqQ.pop_front();
                check("bus_wr", 32'(data_wr), 32'(e.wr));
                check("bus_size", 32'(data_size), 32'(e.size));
                check("bus_addr", data_addr, e.addr);
                if (e.wr) check("bus_wdata", data_wdata, e.wdata);
            end
        end
    end

    // One full access from IDLE: addr_ok aDly cycles after the first REQ cycle, data_ok dDly
    // cycles after addr_ok, longest_stall held high for `hold` cycles of DONE.
    task automatic access(input logic wr, input logic [3:0] sel, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata, input int aDly,
                          input int dDly, input int hold, input logic [1:0] expSize,
                          input logic [31:0] expAddr);
        int          td;
        int          stalls;
        int          hs0;
        logic [31:0] expRd;
        busReq_t     e;
        td     = 2 + aDly + dDly;
        stalls = 0;
        hs0    = hsCnt;
        expRd  = lastRdata;
        core_rd = !wr; core_wr = wr; core_sel = sel; core_addr = addr; core_wdata = wdata;
        cancel = 1'b0;
        e.wr = wr; e.size = expSize; e.addr = expAddr; e.wdata = wdata;
        reqQ.push_back(e);
        rdQ.push_back(wr ? lastRdata : rdata);
        for (int t = 0; t <= td + hold; t++) begin
            data_addr_ok  = (t == 1 + aDly);
            data_data_ok  = (t == 1 + aDly + dDly);
            data_rdata    = data_data_ok ? rdata : 32'hBAD0_BAD0;
            longest_stall = (t >= td) && (t < td + hold);
            @(negedge clk);
            if (data_stall) stalls++;
            if (t == 0) begin
                check("rdata_held", core_rdata, lastRdata);
                check("idle_req", 32'(data_req), 32'd0);
            end
            if (t == 1) check("req_valid", 32'(data_req), 32'd1);
            if (t == td) begin
                expRd = rdQ.pop_front();
                check("rdata_done", core_rdata, expRd);
                check("stall_done", 32'(data_stall), 32'd0);
            end
            if (t > td) begin
                check("hold_req", 32'(data_req), 32'd0);
                check("hold_rdata", core_rdata, expRd);
            end
            nxt();
        end
        core_rd = 1'b0; core_wr = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
        longest_stall = 1'b0;
        check("stall_cycles", 32'(stalls), 32'(td));
        check("one_handshake", 32'(hsCnt - hs0), 32'd1);
        lastRdata = expRd;
    endtask

    initial begin
        int      hs0;
        busReq_t e;
        rst = 1'b0;
        core_rd = 1'b0; core_wr = 1'b0; core_sel = 4'h0; core_addr = 32'h0; core_wdata = 32'h0;
        longest_stall = 1'b0; cancel = 1'b0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;

        @(negedge clk);
        check("rst_req", 32'(data_req), 32'd0);
        check("rst_wr", 32'(data_wr), 32'd0);
        check("rst_size", 32'(data_size), 32'd0);
        check("rst_addr", data_addr, 32'h0);
        check("rst_wdata", data_wdata, 32'h0);
        check("rst_rdata", core_rdata, 32'h0);
        check("rst_stall", 32'(data_stall), 32'd0);
        nxt();
        rst = 1'b1;
        nxt();

        // Word load, addr_ok at +1, data_ok at +3
        access(1'b0, 4'b1111, 32'h8000_0010, 32'h0, 32'hDEAD_BEEF, 0, 2, 0, 2'd2,
               expMap(32'h8000_0010));
        // Byte store
        access(1'b1, 4'b0100, 32'h1FC0_0001, 32'h1122_3344, 32'hCAFE_F00D, 1, 1, 0, 2'd0,
               32'h1FC0_0002);
        // Half load completed while the pipeline stays stalled for 5 cycles
        access(1'b0, 4'b1100, 32'h0000_1000, 32'h0, 32'h55AA_1234, 0, 1, 5, 2'd1, 32'h0000_1002);
        // addr_ok and data_ok together: two stall cycles
        access(1'b0, 4'b1000, 32'h0000_2000, 32'h0, 32'h7700_0000, 0, 0, 0, 2'd0, 32'h0000_2003);
        // sel 0000 read is a word read
        access(1'b0, 4'b0000, 32'h0000_3003, 32'h0, 32'h0102_0304, 2, 0, 0, 2'd2, 32'h0000_3000);

        // Cancel in REQ before addr_ok
        core_rd = 1'b1; core_sel = 4'b1111; core_addr = 32'h0000_0100;
        @(negedge clk);
        check("creq_stall", 32'(data_stall), 32'd1);
        nxt();
        cancel = 1'b1;
        @(negedge clk);
        check("creq_req", 32'(data_req), 32'd1);
        check("creq_nostall", 32'(data_stall), 32'd0);
        nxt();
        cancel = 1'b0; core_rd = 1'b0; data_addr_ok = 1'b1;
        hs0 = hsCnt;
        repeat (3) begin
            @(negedge clk);
            check("creq_dropped", 32'(data_req), 32'd0);
            nxt();
        end
        data_addr_ok = 1'b0;
        check("creq_no_hs", 32'(hsCnt - hs0), 32'd0);

        // Cancel in WAIT: drain data_ok, discard it, then serve the next load
        core_rd = 1'b1; core_sel = 4'b1111; core_addr = 32'h0000_0200;
        e.wr = 1'b0; e.size = 2'd2; e.addr = 32'h0000_0200; e.wdata = 32'h0;
        reqQ.push_back(e);
        @(negedge clk);
        nxt();
        data_addr_ok = 1'b1;
        @(negedge clk);
        nxt();
        data_addr_ok = 1'b0; cancel = 1'b1;
        @(negedge clk);
        check("cwait_nostall", 32'(data_stall), 32'd0);
        nxt();
        cancel = 1'b0; core_addr = 32'h0000_0300;
        @(negedge clk);
        check("cwait_stall", 32'(data_stall), 32'd1);
        check("cwait_noreq", 32'(data_req), 32'd0);
        nxt();
        data_data_ok = 1'b1; data_rdata = 32'h0BAD_F00D;
        @(negedge clk);
        check("cwait_drain_req", 32'(data_req), 32'd0);
        nxt();
        data_data_ok = 1'b0;
        access(1'b0, 4'b1111, 32'h0000_0300, 32'h0, 32'h1357_9BDF, 1, 1, 0, 2'd2, 32'h0000_0300);

        // Reset pulse during WAIT
        core_rd = 1'b1; core_sel = 4'b1111; core_addr = 32'h0000_0400; core_wdata = 32'hFFFF_0000;
        e.wr = 1'b0; e.size = 2'd2; e.addr = 32'h0000_0400; e.wdata = 32'h0;
        reqQ.push_back(e);
        @(negedge clk);
        nxt();
        data_addr_ok = 1'b1;
        @(negedge clk);
        nxt();
        data_addr_ok = 1'b0;
        @(negedge clk);
        nxt();
        rst = 1'b0; core_rd = 1'b0;
        @(negedge clk);
        check("mid_rst_req", 32'(data_req), 32'd0);
        check("mid_rst_wr", 32'(data_wr), 32'd0);
        check("mid_rst_size", 32'(data_size), 32'd0);
        check("mid_rst_addr", data_addr, 32'h0);
        check("mid_rst_wdata", data_wdata, 32'h0);
        check("mid_rst_rdata", core_rdata, 32'h0);
        check("mid_rst_stall", 32'(data_stall), 32'd0);
        nxt();
        rst = 1'b1;
        lastRdata = 32'h0;
        nxt();
        access(1'b0, 4'b0001, 32'h0000_0500, 32'h0, 32'h2468_ACE0, 0, 1, 0, 2'd0, 32'h0000_0500);

        // kseg1 address: translated only when the map is built in
        access(1'b0, 4'b1111, 32'hA000_0004, 32'h0, 32'h0F0F_0F0F, 0, 1, 0, 2'd2,
               expMap(32'hA000_0004));

        check("queue_empty", 32'(reqQ.size()), 32'd0);
        $display("%0d/%0d checks passed", passCnt, passCnt + failCnt);
        $finish;
    end

endmodule
